// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared state encoding, default configuration and width helper for seq_detector_param
// Contents: state_t (S_FILL/S_HUNT), DEF_* defaults, len_w() = bits needed to hold 0..max_len
package seq_det_pkg;
  typedef enum logic {S_FILL = 1'b0, S_HUNT = 1'b1} state_t;
  localparam int DEF_MAX_LEN = 8;
  localparam logic [7:0] DEF_PATTERN_C = 8'h0D;
  localparam int DEF_LEN_C = 4;
  localparam bit DEF_OVERLAP_C = 1'b1;
`ifdef SEQDET_COUNT_EN
  localparam int DEF_CNT_W = 8;
`endif
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction
endpackage

// File: rtl/seq_hist_shreg.sv
// seq_hist_shreg: W-bit history shift register, newest bit enters at bit 0
// Ports: clk, rst (sync active-low), clr (sync clear), en (shift enable), d (new bit), q (history)
module seq_hist_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    if (!rst || clr) q <= '0;
    else if (en) q <= {q[W-2:0], d};
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-programmable serial pattern detector with registered 1-cycle match pulse
// Ports: clk, rst (sync active-low), in_valid/in_bit (serial input), cfg_load/cfg_pattern/cfg_len/cfg_overlap
//   (runtime config), out (match pulse), cfg_err (rejected config pulse),
//   match_count (saturating match counter, present only when SEQDET_COUNT_EN is defined)
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DEF_PATTERN_C),
  parameter int DEF_LEN = DEF_LEN_C,
  parameter bit DEF_OVERLAP = DEF_OVERLAP_C,
`ifdef SEQDET_COUNT_EN
  parameter int CNT_W = DEF_CNT_W,
`endif
  localparam int LEN_W = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
`ifdef SEQDET_COUNT_EN
  output logic [CNT_W-1:0]   match_count,
`endif
  output logic               cfg_err
);
  logic [MAX_LEN-1:0] pat, hist, hist_next, mask;
  logic [LEN_W-1:0] len, fill, fill_inc, fill_next;
  logic ovl, cfg_ok, shift, hit, err_d;
  state_t state, state_next;
  seq_hist_shreg #(.W(MAX_LEN)) u_hist (
    .clk(clk),
    .rst(rst),
    .clr(cfg_load && cfg_ok),
    .en(shift),
    .d(in_bit),
    .q(hist)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= S_FILL;
      fill <= '0;
    end else begin
      state <= state_next;
      fill <= fill_next;
    end
  // cfg_load takes the edge even when rejected, so the coincident in_bit is dropped
  always_comb begin
    cfg_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
    shift = in_valid && !cfg_load;
    fill_inc = state == S_HUNT ? len : fill + LEN_W'(1);
    fill_next = cfg_load ? (cfg_ok ? '0 : fill) : !shift ? fill : (hit && !ovl) ? '0 : fill_inc;
    state_next = (cfg_load || shift) ? (fill_next == len ? S_HUNT : S_FILL) : state;
  end
  // mask keeps only the low len bits so unused pattern bits never take part in the compare
  always_comb begin
    hist_next = {hist[MAX_LEN-2:0], in_bit};
    mask = ~({MAX_LEN{1'b1}} << len);
    hit = shift && fill_inc == len && ((hist_next ^ pat) & mask) == '0;
    err_d = cfg_load && !cfg_ok;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      pat <= DEF_PATTERN;
      len <= LEN_W'(DEF_LEN);
      ovl <= DEF_OVERLAP;
    end else if (cfg_load && cfg_ok) begin
      pat <= cfg_pattern;
      len <= cfg_len;
      ovl <= cfg_overlap;
    end
  always_ff @(posedge clk)
    if (!rst) begin
      out <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      out <= hit;
      cfg_err <= err_d;
    end
`ifdef SEQDET_COUNT_EN
  always_ff @(posedge clk)
    if (!rst || (cfg_load && cfg_ok)) match_count <= '0;
    else if (hit && match_count != '1) match_count <= match_count + CNT_W'(1);
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed scoreboard bench for seq_detector_param (counter checked when SEQDET_COUNT_EN)
module tb_seq_detector_param;
  logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_bit = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic out, cfg_err;
`ifdef SEQDET_COUNT_EN
  logic [1:0] match_count;
`endif
  always #5 clk = ~clk;
  seq_detector_param #(
`ifdef SEQDET_COUNT_EN
    .CNT_W(2),
`endif
    .MAX_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .out(out),
`ifdef SEQDET_COUNT_EN
    .match_count(match_count),
`endif
    .cfg_err(cfg_err)
  );
  typedef struct {
    logic o;
    logic e;
    int c;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0;
  logic [7:0] m_pat = 8'h0D;
  int m_len = 4, m_cnt = 0;
  bit m_ovl = 1'b1;
  bit m_q[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic b, input logic ld,
                      input logic [7:0] p, input logic [3:0] l, input logic ov, output logic o);
    exp_t x;
    bit m;
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; cfg_load = ld; cfg_pattern = p; cfg_len = l; cfg_overlap = ov;
    x.o = 1'b0;
    x.e = 1'b0;
    if (!r) begin
      m_pat = 8'h0D; m_len = 4; m_ovl = 1'b1; m_cnt = 0; m_q.delete();
    end else if (ld) begin
      if (l >= 1 && l <= 8) begin
        m_pat = p; m_len = int'(l); m_ovl = ov; m_cnt = 0; m_q.delete();
      end else x.e = 1'b1;
    end else if (v) begin
      m_q.push_back(b);
      if (m_q.size() > m_len) void'(m_q.pop_front());
      if (m_q.size() == m_len) begin
        m = 1'b1;
        for (int i = 0; i < m_len; i++) if (m_q[i] != m_pat[m_len-1-i]) m = 1'b0;
        if (m) begin
          x.o = 1'b1;
          if (m_cnt < 3) m_cnt++;
          if (!m_ovl) m_q.delete();
        end
      end
    end
    x.c = m_cnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("out", 32'(out), 32'(x.o));
    check("cfg_err", 32'(cfg_err), 32'(x.e));
`ifdef SEQDET_COUNT_EN
    check("match_count", 32'(match_count), 32'(x.c));
`endif
    o = out;
  endtask
  task automatic run(input string tag, input logic [31:0] bits, input int n, input logic [31:0] exp);
    logic [31:0] pv;
    logic o;
    pv = '0;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, bits[n-1-i], 1'b0, 8'h00, 4'd0, 1'b0, o);
      pv[i] = o;
    end
    check(tag, pv, exp);
  endtask
  initial begin
    logic o;
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, o);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, o);
    run("dflt_ovl", 32'b1101101, 7, 32'h48);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h0D, 4'd4, 1'b0, o);
    run("no_ovl", 32'b1101101, 7, 32'h8);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'h0D, 4'd4, 1'b1, o);
    run("long", 32'b11100011010110110111, 20, 32'h24200);
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0D, 4'd0, 1'b1, o);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd9, 1'b0, o);
    run("keep_cfg", 32'b01, 2, 32'h2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0, o);
    check("discard", 32'(o), 32'h0);
    run("len1", 32'b1011, 4, 32'hD);
    run("pre_rst", 32'b110, 3, 32'h3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, o);
    run("post_rst", 32'b1101, 4, 32'h8);
    run("sat", 32'b101101101, 9, 32'h124);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hF5, 4'd3, 1'b1, o);
    run("mask", 32'b10101, 5, 32'h14);
    step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, o);
    run("gap", 32'b01, 2, 32'h2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 4'd8, 1'b0, o);
    run("len8", 32'b1010010110100101, 16, 32'h8080);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
